k_means_agg_scheduler: RTL

Sequences the aggregation phase of the k-means accumulation pipelines. Waits until every accumulation pipeline has finished its iteration. Then grants each pipeline in turn the right to dump its result. Each dump is cluster counts, then per-dimension sums, then SSE. All dumps are merged into one tagged 64-bit stream for the downstream aggregator. The block sits between the NUM_PIPELINE accumulation units and the aggregator, and owns every agg_ready handshake.

---
 rtl/k_means_agg_scheduler_if.sv | 37 +++
 rtl/k_means_agg_scheduler.sv | 128 ++++++++++++
 2 files changed

// File: rtl/k_means_agg_scheduler_if.sv
// Handshake bundle between the aggregation scheduler, the accumulation pipelines and the aggregator.
// master = scheduler side, slave = pipelines/aggregator side.
interface k_means_agg_scheduler_if #(
   parameter int NUM_PIPELINE     = 4,
   parameter int NUM_CLUSTER_BITS = 3,
   parameter int MAX_DEPTH_BITS   = 9,
   parameter int PID_BITS         = $clog2(NUM_PIPELINE)
);
   logic                               start_i;
   logic [MAX_DEPTH_BITS:0]            data_dim_i;
   logic [NUM_CLUSTER_BITS:0]          num_cluster_i;
   logic [NUM_PIPELINE-1:0]            accu_finish_i;
   logic [NUM_PIPELINE-1:0]            agg_ready_o;
   logic [NUM_PIPELINE-1:0]            agg_valid_i;
   logic [NUM_PIPELINE-1:0][63:0]      agg_data_i;
   logic                               out_space_i;
   logic                               out_valid_o;
   logic [63:0]                        out_data_o;
   logic [PID_BITS-1:0]                out_pid_o;
   logic                               out_last_o;
   logic                               iter_done_o;
   logic                               error_o;

   modport master (
      input  start_i, data_dim_i, num_cluster_i, accu_finish_i,
      input  agg_valid_i, agg_data_i, out_space_i,
      output agg_ready_o, out_valid_o, out_data_o, out_pid_o, out_last_o,
      output iter_done_o, error_o
   );

   modport slave (
      output start_i, data_dim_i, num_cluster_i, accu_finish_i,
      output agg_valid_i, agg_data_i, out_space_i,
      input  agg_ready_o, out_valid_o, out_data_o, out_pid_o, out_last_o,
      input  iter_done_o, error_o
   );
endinterface

// File: rtl/k_means_agg_scheduler.sv
// Grants each accumulation pipeline in ascending order and merges their dumps into one tagged stream.
// Merged words lag agg_valid_i by one cycle; grants wait for out_space_i, pipelines are never stalled mid-dump.
module k_means_agg_scheduler #(
   parameter int NUM_PIPELINE     = 4,
   parameter int NUM_CLUSTER_BITS = 3,
   parameter int MAX_DEPTH_BITS   = 9,
   parameter int PID_BITS         = $clog2(NUM_PIPELINE)
) (
   input  logic                         clk,
   input  logic                         rst,
   k_means_agg_scheduler_if.master      bus
);
   localparam int WB = NUM_CLUSTER_BITS + MAX_DEPTH_BITS + 2;

   typedef enum logic [2:0] {IDLE, WAIT_FIN, ARB, DRAIN, DONE} state_t;

   state_t                  state;
   logic [PID_BITS-1:0]     pid;
   logic [WB-1:0]           word_cnt;
   logic [WB-1:0]           words;
   logic [NUM_PIPELINE-1:0] finished;
   logic [NUM_PIPELINE-1:0] grant_mask;
   logic [NUM_PIPELINE-1:0] stray;
   logic                    hit;
   logic                    last_word;
   logic                    start_ok;

   logic [NUM_PIPELINE-1:0] agg_ready;
   logic                    out_valid;
   logic [63:0]             out_data;
   logic [PID_BITS-1:0]     out_pid;
   logic                    out_last;
   logic                    iter_done;
   logic                    error;

   assign grant_mask = {{(NUM_PIPELINE-1){1'b0}}, 1'b1} << pid;
   // Outside DRAIN every valid is unexpected; inside DRAIN only the granted pipeline may talk.
   assign stray      = (state == DRAIN) ? (bus.agg_valid_i & ~grant_mask) : bus.agg_valid_i;
   assign hit        = (state == DRAIN) && |(bus.agg_valid_i & grant_mask);
   assign last_word  = (word_cnt + WB'(1)) == words;
   assign start_ok   = bus.start_i && (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pid       <= '0;
         word_cnt  <= '0;
         words     <= '0;
         finished  <= '0;
         agg_ready <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_pid   <= '0;
         out_last  <= 1'b0;
         iter_done <= 1'b0;
         error     <= 1'b0;
      end else begin
         agg_ready <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         iter_done <= 1'b0;

         if (|stray || (bus.start_i && state != IDLE))
            error <= 1'b1;

         // Clearing wins over a finish arriving in the same cycle.
         if (start_ok || state == DONE)
            finished <= '0;
         else
            finished <= finished | bus.accu_finish_i;

         if (hit) begin
            out_valid <= 1'b1;
            out_data  <= bus.agg_data_i[pid];
            out_pid   <= pid;
            out_last  <= last_word;
            word_cnt  <= word_cnt + WB'(1);
         end

         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  words <= WB'(bus.num_cluster_i)
                         + WB'(bus.num_cluster_i) * WB'(bus.data_dim_i)
                         + WB'(1);
                  state <= WAIT_FIN;
               end
            end
            WAIT_FIN: begin
               if (&finished) begin
                  pid   <= '0;
                  state <= ARB;
               end
            end
            ARB: begin
               if (bus.out_space_i) begin
                  agg_ready <= grant_mask;
                  word_cnt  <= '0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (hit && last_word) begin
                  if (pid == PID_BITS'(NUM_PIPELINE - 1)) begin
                     state <= DONE;
                  end else begin
                     pid   <= pid + PID_BITS'(1);
                     state <= ARB;
                  end
               end
            end
            DONE: begin
               iter_done <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.agg_ready_o = agg_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_data;
   assign bus.out_pid_o   = out_pid;
   assign bus.out_last_o  = out_last;
   assign bus.iter_done_o = iter_done;
   assign bus.error_o     = error;
endmodule
